// File: rtl/rice_core_alu_arbiter.sv
// rice_core_alu_arbiter
// Shares one combinational ALU between REQUESTERS clients. Each cycle a
// round-robin grant picks one valid requester, its operands are steered to
// the ALU, and the ALU result is captured into a single result slot. The slot
// is returned to the requester that issued it and can be drained and refilled
// in the same cycle.
//
// Handshake semantics (both request and response channels):
//   A transfer happens on a rising edge when valid & ready are both high for
//   the same requester index. Ready never waits on the requester's own valid
//   (beyond choosing which requester is granted). A requester may drop valid
//   before its transfer without loss. Once a response is valid, the slot
//   holds its result and owner until that owner raises i_rsp_ready.
//
// The ALU command is carried as an opaque packed vector of OP_WIDTH bits
// (the packed form of rice_core_alu_operation); it is only steered, never
// decoded here.
module rice_core_alu_arbiter #(
    parameter int XLEN       = 32,
    parameter int REQUESTERS = 2,
    parameter int OP_WIDTH   = 8
) (
    input  logic                                 i_clk,
    input  logic                                 i_rst,
    input  logic [REQUESTERS-1:0]                i_req_valid,
    output logic [REQUESTERS-1:0]                o_req_ready,
    input  logic [REQUESTERS-1:0][XLEN-1:0]      i_req_pc,
    input  logic [REQUESTERS-1:0][XLEN-1:0]      i_req_rs1_value,
    input  logic [REQUESTERS-1:0][XLEN-1:0]      i_req_rs2_value,
    input  logic [REQUESTERS-1:0][XLEN-1:0]      i_req_imm_value,
    input  logic [REQUESTERS-1:0][OP_WIDTH-1:0]  i_req_alu_operation,
    output logic [XLEN-1:0]                      o_alu_pc,
    output logic [XLEN-1:0]                      o_alu_rs1_value,
    output logic [XLEN-1:0]                      o_alu_rs2_value,
    output logic [XLEN-1:0]                      o_alu_imm_value,
    output logic [OP_WIDTH-1:0]                  o_alu_operation,
    input  logic [XLEN-1:0]                      i_alu_result,
    output logic [REQUESTERS-1:0]                o_rsp_valid,
    input  logic [REQUESTERS-1:0]                i_rsp_ready,
    output logic [XLEN-1:0]                      o_rsp_result
);

    // Index width for owner and round-robin pointer; at least one bit so a
    // single-requester build still has a (constant zero) pointer.
    localparam int IDX_W = (REQUESTERS > 1) ? $clog2(REQUESTERS) : 1;

    // Result slot state
    logic              full_q,   full_d;
    logic [IDX_W-1:0]  owner_q,  owner_d;
    logic [XLEN-1:0]   result_q, result_d;
    logic [IDX_W-1:0]  ptr_q,    ptr_d;

    // Arbitration / handshake terms
    logic              any_valid;
    logic [IDX_W-1:0]  grant_idx;
    logic              slot_free;
    logic              xfer;

    // Round-robin search: first valid requester at or above the pointer,
    // wrapping from REQUESTERS-1 back to 0.
    always_comb begin
        int               idx;
        logic [IDX_W-1:0] cand;
        any_valid = 1'b0;
        grant_idx = '0;
        idx       = 0;
        cand      = '0;
        for (int i = 0; i < REQUESTERS; i++) begin
            idx = int'(ptr_q) + i;
            if (idx >= REQUESTERS) begin
                idx = idx - REQUESTERS;
            end
            cand = IDX_W'(idx);
            if (!any_valid && i_req_valid[cand]) begin
                any_valid = 1'b1;
                grant_idx = cand;
            end
        end
    end

    // The slot can take a new result when empty, or when its current owner
    // is draining it this cycle. Only the owner's rsp_ready is looked at.
    assign slot_free = ~full_q | i_rsp_ready[owner_q];
    assign xfer      = any_valid & slot_free & ~i_rst;

    // Next-state: capture on transfer, otherwise empty the slot on drain.
    always_comb begin
        full_d   = full_q;
        owner_d  = owner_q;
        result_d = result_q;
        ptr_d    = ptr_q;
        if (xfer) begin
            full_d   = 1'b1;
            owner_d  = grant_idx;
            result_d = i_alu_result;
            if (grant_idx == IDX_W'(REQUESTERS - 1)) begin
                ptr_d = '0;
            end else begin
                ptr_d = grant_idx + IDX_W'(1);
            end
        end else if (full_q && i_rsp_ready[owner_q]) begin
            full_d = 1'b0;
        end
    end

    // State register; reset discards any pending result immediately.
    always_ff @(posedge i_clk or posedge i_rst) begin
        if (i_rst) begin
            full_q   <= 1'b0;
            owner_q  <= '0;
            result_q <= '0;
            ptr_q    <= '0;
        end else begin
            full_q   <= full_d;
            owner_q  <= owner_d;
            result_q <= result_d;
            ptr_q    <= ptr_d;
        end
    end

    // Outputs: one-hot ready for the granted requester, one-hot response
    // valid for the owner, and the granted operands steered to the ALU.
    always_comb begin
        o_req_ready = '0;
        if (xfer) begin
            o_req_ready[grant_idx] = 1'b1;
        end
        o_rsp_valid = '0;
        if (full_q) begin
            o_rsp_valid[owner_q] = 1'b1;
        end
        o_rsp_result    = result_q;
        o_alu_pc        = '0;
        o_alu_rs1_value = '0;
        o_alu_rs2_value = '0;
        o_alu_imm_value = '0;
        o_alu_operation = '0;
        if (any_valid) begin
            o_alu_pc        = i_req_pc[grant_idx];
            o_alu_rs1_value = i_req_rs1_value[grant_idx];
            o_alu_rs2_value = i_req_rs2_value[grant_idx];
            o_alu_imm_value = i_req_imm_value[grant_idx];
            o_alu_operation = i_req_alu_operation[grant_idx];
        end
    end

endmodule

// File: tb/tb_rice_core_alu_arbiter.sv
// tb_rice_core_alu_arbiter
// Randomized and directed stimulus against a queue-based reference model of
// the shared-ALU arbiter. A small behavioural ALU closes the loop on the
// DUT's ALU port.
module tb_rice_core_alu_arbiter;

    localparam int XLEN = 32;
    localparam int REQ  = 4;
    localparam int OPW  = 8;

    // Command encoding used by the bench ALU:
    //   [1:0] 0 add, 1 sub, 2 xor, 3 and; [2] src2 = imm; [3] src1 = pc
    localparam logic [OPW-1:0] OP_ADDI = 8'h04;
    localparam logic [OPW-1:0] OP_SUB  = 8'h01;

    // ---------------- clock / reset ----------------
    logic clk = 1'b0;
    logic rst;
    always #5 clk = ~clk;

    // ---------------- DUT signals ----------------
    logic [REQ-1:0]                req_valid;
    logic [REQ-1:0]                req_ready;
    logic [REQ-1:0][XLEN-1:0]      pc, rs1, rs2, imm;
    logic [REQ-1:0][OPW-1:0]       op;
    logic [XLEN-1:0]               alu_pc, alu_rs1, alu_rs2, alu_imm;
    logic [OPW-1:0]                alu_op;
    logic [XLEN-1:0]               alu_result;
    logic [REQ-1:0]                rsp_valid;
    logic [REQ-1:0]                rsp_ready;
    logic [XLEN-1:0]               rsp_result;

    rice_core_alu_arbiter #(
        .XLEN       (XLEN),
        .REQUESTERS (REQ),
        .OP_WIDTH   (OPW)
    ) dut (
        .i_clk               (clk),
        .i_rst               (rst),
        .i_req_valid         (req_valid),
        .o_req_ready         (req_ready),
        .i_req_pc            (pc),
        .i_req_rs1_value     (rs1),
        .i_req_rs2_value     (rs2),
        .i_req_imm_value     (imm),
        .i_req_alu_operation (op),
        .o_alu_pc            (alu_pc),
        .o_alu_rs1_value     (alu_rs1),
        .o_alu_rs2_value     (alu_rs2),
        .o_alu_imm_value     (alu_imm),
        .o_alu_operation     (alu_op),
        .i_alu_result        (alu_result),
        .o_rsp_valid         (rsp_valid),
        .i_rsp_ready         (rsp_ready),
        .o_rsp_result        (rsp_result)
    );

    function automatic logic [XLEN-1:0] alu_f(input logic [OPW-1:0] o,
                                              input logic [XLEN-1:0] p,
                                              input logic [XLEN-1:0] a1,
                                              input logic [XLEN-1:0] a2,
                                              input logic [XLEN-1:0] im);
        logic [XLEN-1:0] a, b;
        a = o[3] ? p : a1;
        b = o[2] ? im : a2;
        case (o[1:0])
            2'd0:    return a + b;
            2'd1:    return a - b;
            2'd2:    return a ^ b;
            default: return a & b;
        endcase
    endfunction

    assign alu_result = alu_f(alu_op, alu_pc, alu_rs1, alu_rs2, alu_imm);

    // ---------------- reference model / scoreboard ----------------
    logic [XLEN-1:0] exp_q[$];   // result waiting in the slot (0 or 1 entry)
    int              m_owner;
    int              m_ptr;
    int              n_cmp = 0;
    int              n_err = 0;
    logic [REQ-1:0]  ready_seen;

    task automatic check(input string tag, input logic [63:0] got, input logic [63:0] exp);
        n_cmp++;
        if (got !== exp) begin
            n_err++;
            $display("FAIL %s t=%0t got=%0h exp=%0h", tag, $time, got, exp);
        end
    endtask

    // ---------------- driver tasks ----------------
    task automatic set_req(input int r, input logic [OPW-1:0] o, input logic [XLEN-1:0] a1,
                           input logic [XLEN-1:0] a2, input logic [XLEN-1:0] im);
        op[r]  = o;
        pc[r]  = $urandom;
        rs1[r] = a1;
        rs2[r] = a2;
        imm[r] = im;
    endtask

    task automatic randomize_operands();
        for (int r = 0; r < REQ; r++) begin
            set_req(r, OPW'($urandom), $urandom, $urandom, $urandom);
        end
    endtask

    // Called just after a falling edge with inputs already driven. Checks all
    // outputs against the model mid-low-phase, then advances the model on the
    // rising edge, and returns at the next falling edge.
    task automatic run_cycle();
        int             g;
        logic           free;
        logic [REQ-1:0] exp_ready;
        logic [REQ-1:0] exp_vld;
        #2;
        free = (exp_q.size() == 0) || rsp_ready[m_owner];
        g = -1;
        for (int k = 0; k < REQ; k++) begin
            if (g < 0 && req_valid[(m_ptr + k) % REQ]) g = (m_ptr + k) % REQ;
        end
        exp_ready = '0;
        if (g >= 0 && free && !rst) exp_ready[g] = 1'b1;
        exp_vld = '0;
        if (exp_q.size() != 0) exp_vld[m_owner] = 1'b1;
        check("req_ready", req_ready, exp_ready);
        check("rsp_valid", rsp_valid, exp_vld);
        if (rst) check("rsp_result_rst", rsp_result, 0);
        else if (exp_q.size() != 0) check("rsp_result", rsp_result, exp_q[0]);
        if (g >= 0) begin
            check("alu_pc",  alu_pc,  pc[g]);
            check("alu_rs1", alu_rs1, rs1[g]);
            check("alu_rs2", alu_rs2, rs2[g]);
            check("alu_imm", alu_imm, imm[g]);
            check("alu_op",  alu_op,  op[g]);
        end else begin
            check("alu_idle", {alu_pc ^ alu_rs1, alu_rs2 | alu_imm}, 0);
            check("alu_idle_op", alu_op, 0);
            check("alu_idle_pc", alu_pc, 0);
        end
        ready_seen = req_ready;
        @(posedge clk);
        if (!rst) begin
            if (exp_q.size() != 0 && rsp_ready[m_owner]) void'(exp_q.pop_front());
            if (exp_ready != '0) begin
                exp_q.push_back(alu_f(op[g], pc[g], rs1[g], rs2[g], imm[g]));
                m_owner = g;
                m_ptr   = (g + 1) % REQ;
            end
        end
        @(negedge clk);
    endtask

    task automatic model_reset();
        exp_q.delete();
        m_ptr   = 0;
        m_owner = 0;
    endtask

    task automatic do_reset();
        rst = 1'b1;
        model_reset();
        randomize_operands();
        req_valid = '1;
        rsp_ready = '1;
        repeat (2) run_cycle();
        rst = 1'b0;
    endtask

    // ---------------- main sequence ----------------
    initial begin
        rst       = 1'b1;
        req_valid = '0;
        rsp_ready = '0;
        randomize_operands();
        do_reset();

        // Single ADD with immediate, first edge after reset release
        req_valid = 4'b0001;
        rsp_ready = '1;
        set_req(0, OP_ADDI, 32'd5, $urandom, 32'd7);
        run_cycle();
        check("single_ready", ready_seen, 4'b0001);
        check("single_vld", rsp_valid, 4'b0001);
        check("single_res", rsp_result, 32'd12);
        req_valid = '0;
        run_cycle();

        // Contention between requesters 0 and 1 from a fresh reset
        do_reset();
        req_valid = 4'b0011;
        rsp_ready = '1;
        for (int i = 0; i < 6; i++) begin
            randomize_operands();
            run_cycle();
            check("rr_grant", ready_seen, (i % 2 == 0) ? 4'b0001 : 4'b0010);
            check("rr_rsp", rsp_valid, (i % 2 == 0) ? 4'b0001 : 4'b0010);
        end

        // Backpressure on owner 0 while other requesters' rsp_ready are high
        req_valid = 4'b0001;
        set_req(0, OP_SUB, 32'd10, 32'd3, $urandom);
        run_cycle();
        check("bp_first", ready_seen, 4'b0001);
        req_valid = 4'b0011;
        rsp_ready = 4'b1110;
        for (int i = 0; i < 3; i++) begin
            run_cycle();
            check("bp_stall_ready", ready_seen, 4'b0000);
            check("bp_hold_res", rsp_result, 32'd7);
            check("bp_hold_vld", rsp_valid, 4'b0001);
        end
        rsp_ready = '1;
        run_cycle();
        check("bp_refill", ready_seen, 4'b0010);

        // Pointer wrap and skip: pointer is now 2
        req_valid = 4'b0100;
        run_cycle();
        check("wrap_g2", ready_seen, 4'b0100);
        req_valid = 4'b0101;
        run_cycle();
        check("wrap_g0", ready_seen, 4'b0001);
        run_cycle();
        check("wrap_skip_g2", ready_seen, 4'b0100);

        // Randomized traffic
        for (int i = 0; i < 400; i++) begin
            randomize_operands();
            req_valid = REQ'($urandom);
            for (int r = 0; r < REQ; r++) rsp_ready[r] = ($urandom_range(0, 3) != 0);
            run_cycle();
        end

        // Asynchronous reset with a full slot
        req_valid = '0;
        rsp_ready = '1;
        run_cycle();
        req_valid = 4'b0001;
        rsp_ready = '0;
        set_req(0, OP_ADDI, 32'hDEADBEEF, $urandom, 32'd0);
        run_cycle();
        check("arst_pre_vld", rsp_valid, 4'b0001);
        check("arst_pre_res", rsp_result, 32'hDEADBEEF);
        #2 rst = 1'b1;
        #1;
        check("arst_vld", rsp_valid, 4'b0000);
        check("arst_res", rsp_result, 32'd0);
        check("arst_ready", req_ready, 4'b0000);
        model_reset();
        @(negedge clk);
        run_cycle();
        rst = 1'b0;
        req_valid = '1;
        rsp_ready = '1;
        run_cycle();
        check("arst_first_grant", ready_seen, 4'b0001);
        run_cycle();

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
        $finish;
    end

endmodule
